// File: rtl/qea_run_sequencer.sv
// qea_run_sequencer
//   Upstream control stage for QEA. Runs one emulation job:
//     1. Streams n gate-context words from a valid/ready source into the QEA ctx RAM.
//     2. Initialises the state RAM to |0...0> (2**(qn-PE_NUM_WIDTH) words).
//     3. Pulses QEA start, waits for completion and reports the run length in cycles.
//
//   Optional feature
//     QEA_RUN_SEQUENCER_WDOG_EN     when defined, a run that reaches WDOG_CYCLES cycles
//                                   without completion is abandoned with an o_err pulse.
//
//   All outputs are registered; a write strobe appears the cycle after its source event.

module qea_run_sequencer #(
  parameter int unsigned PE_NUM_WIDTH            = 2,
  parameter int unsigned PE_NUM                  = 4,
  parameter int unsigned DATA_WIDTH              = 32,
  parameter int unsigned NUM_FRAC_BIT            = 30,
  parameter int unsigned STATE_DATA_WIDTH        = 64,
  parameter int unsigned STATE_ADDR_WIDTH        = 16,
  parameter int unsigned GATE_CONTEXT_DATA_WIDTH = 64,
  parameter int unsigned GATE_CONTEXT_ADDR_WIDTH = 16,
  parameter int unsigned MAX_QBIT_WIDTH          = 6,
  parameter int unsigned CNT_WIDTH               = 32,
  parameter int unsigned WDOG_CYCLES             = 2**24
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 i_launch,
  input  logic [MAX_QBIT_WIDTH-1:0]            i_qbit_num,
  input  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   i_ins_num,
  input  logic                                 i_ctx_valid,
  output logic                                 o_ctx_ready,
  input  logic [GATE_CONTEXT_DATA_WIDTH-1:0]   i_ctx_word,
  output logic                                 o_ctx_en,
  output logic                                 o_ctx_wea,
  output logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   o_ctx_addr,
  output logic [GATE_CONTEXT_DATA_WIDTH-1:0]   o_ctx_data,
  output logic                                 o_state_ena,
  output logic                                 o_state_wea,
  output logic [STATE_ADDR_WIDTH-1:0]          o_state_addra,
  output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_state_dina,
  output logic                                 o_start,
  input  logic                                 i_complete,
  output logic                                 o_busy,
  output logic                                 o_done,
  output logic                                 o_err,
  output logic [CNT_WIDTH-1:0]                 o_cycle_cnt
);

  localparam int unsigned STATE_WORD_WIDTH = PE_NUM * STATE_DATA_WIDTH;

  // Legal qubit range: at least one full state word, at most the whole state RAM.
  localparam logic [MAX_QBIT_WIDTH-1:0] QN_MIN = MAX_QBIT_WIDTH'(PE_NUM_WIDTH);
  localparam logic [MAX_QBIT_WIDTH-1:0] QN_MAX = MAX_QBIT_WIDTH'(STATE_ADDR_WIDTH + PE_NUM_WIDTH);

  // Amplitude 1.0 + 0i on lane 0 (MSBs); every other lane is zero.
  localparam logic [DATA_WIDTH-1:0]       AMP_ONE  = DATA_WIDTH'(1) << NUM_FRAC_BIT;
  localparam logic [STATE_DATA_WIDTH-1:0] LANE_ONE =
    {AMP_ONE, {(STATE_DATA_WIDTH - DATA_WIDTH){1'b0}}};
  localparam logic [STATE_WORD_WIDTH-1:0] WORD_ONE =
    {LANE_ONE, {(STATE_WORD_WIDTH - STATE_DATA_WIDTH){1'b0}}};

  typedef enum logic [2:0] {
    StIdle,
    StCtx,
    StState,
    StStart,
    StRun,
    StDone
  } state_e;

  state_e                               state_q;
  logic [MAX_QBIT_WIDTH-1:0]            qn_q;
  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   n_q;
  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   ctx_idx_q;
  logic [STATE_ADDR_WIDTH-1:0]          st_idx_q;
  logic                                 first_q;

  logic                                 ctx_ready_q;
  logic                                 ctx_en_q;
  logic                                 ctx_wea_q;
  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   ctx_addr_q;
  logic [GATE_CONTEXT_DATA_WIDTH-1:0]   ctx_data_q;
  logic                                 state_ena_q;
  logic                                 state_wea_q;
  logic [STATE_ADDR_WIDTH-1:0]          state_addra_q;
  logic [STATE_WORD_WIDTH-1:0]          state_dina_q;
  logic                                 start_q;
  logic                                 busy_q;
  logic                                 done_q;
  logic                                 err_q;
  logic [CNT_WIDTH-1:0]                 cnt_q;

  logic                                 qn_ok;
  logic [MAX_QBIT_WIDTH-1:0]            qn_shift;
  logic [STATE_ADDR_WIDTH:0]            st_last;
  logic                                 ctx_accept;

  always_comb begin
    qn_ok      = (i_qbit_num >= QN_MIN) && (i_qbit_num <= QN_MAX);
    qn_shift   = qn_q - QN_MIN;
    // One bit wider so the max qubit count (2**STATE_ADDR_WIDTH words) does not overflow.
    st_last    = ((STATE_ADDR_WIDTH + 1)'(1) << qn_shift) - (STATE_ADDR_WIDTH + 1)'(1);
    ctx_accept = i_ctx_valid && ctx_ready_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      qn_q          <= '0;
      n_q           <= '0;
      ctx_idx_q     <= '0;
      st_idx_q      <= '0;
      first_q       <= 1'b0;
      ctx_ready_q   <= 1'b0;
      ctx_en_q      <= 1'b0;
      ctx_wea_q     <= 1'b0;
      ctx_addr_q    <= '0;
      ctx_data_q    <= '0;
      state_ena_q   <= 1'b0;
      state_wea_q   <= 1'b0;
      state_addra_q <= '0;
      state_dina_q  <= '0;
      start_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      cnt_q         <= '0;
    end else begin
      ctx_en_q    <= 1'b0;
      ctx_wea_q   <= 1'b0;
      state_ena_q <= 1'b0;
      state_wea_q <= 1'b0;
      start_q     <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (i_launch) begin
            qn_q <= i_qbit_num;
            n_q  <= i_ins_num;
            if (!qn_ok) begin
              err_q <= 1'b1;
            end else begin
              busy_q    <= 1'b1;
              ctx_idx_q <= '0;
              st_idx_q  <= '0;
              if (i_ins_num == '0) begin
                state_q <= StState;
              end else begin
                ctx_ready_q <= 1'b1;
                state_q     <= StCtx;
              end
            end
          end
        end

        StCtx: begin
          if (ctx_accept) begin
            ctx_en_q   <= 1'b1;
            ctx_wea_q  <= 1'b1;
            ctx_addr_q <= ctx_idx_q;
            ctx_data_q <= i_ctx_word;
            ctx_idx_q  <= ctx_idx_q + GATE_CONTEXT_ADDR_WIDTH'(1);
            if (ctx_idx_q == n_q - GATE_CONTEXT_ADDR_WIDTH'(1)) begin
              ctx_ready_q <= 1'b0;
              state_q     <= StState;
            end
          end
        end

        StState: begin
          state_ena_q   <= 1'b1;
          state_wea_q   <= 1'b1;
          state_addra_q <= st_idx_q;
          state_dina_q  <= (st_idx_q == '0) ? WORD_ONE : '0;
          st_idx_q      <= st_idx_q + STATE_ADDR_WIDTH'(1);
          if ({1'b0, st_idx_q} == st_last) begin
            state_q <= StStart;
          end
        end

        StStart: begin
          start_q <= 1'b1;
          cnt_q   <= '0;
          first_q <= 1'b1;
          state_q <= StRun;
        end

        StRun: begin
          first_q <= 1'b0;
          // The first RUN cycle still sees the completion level of the previous job.
          if (!first_q && i_complete) begin
            done_q  <= 1'b1;
            state_q <= StDone;
`ifdef QEA_RUN_SEQUENCER_WDOG_EN
          end else if (cnt_q == CNT_WIDTH'(WDOG_CYCLES)) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StIdle;
`endif
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + CNT_WIDTH'(1);
          end
        end

        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign o_ctx_ready   = ctx_ready_q;
  assign o_ctx_en      = ctx_en_q;
  assign o_ctx_wea     = ctx_wea_q;
  assign o_ctx_addr    = ctx_addr_q;
  assign o_ctx_data    = ctx_data_q;
  assign o_state_ena   = state_ena_q;
  assign o_state_wea   = state_wea_q;
  assign o_state_addra = state_addra_q;
  assign o_state_dina  = state_dina_q;
  assign o_start       = start_q;
  assign o_busy        = busy_q;
  assign o_done        = done_q;
  assign o_err         = err_q;
  assign o_cycle_cnt   = cnt_q;

endmodule
